// File: rtl/pix_burst_packer_if.sv
// DDR packet-write port bundle between pix_burst_packer (master) and the DDR writer (slave).
interface pix_burst_packer_if;
  logic [31:0] pkg_wr_addr;
  logic        pkg_wr_areq;
  logic [31:0] pkg_wr_size;
  logic [31:0] pkg_wr_data;
  logic        pkg_wr_en;
  logic        pkg_wr_last;

  modport master (
    output pkg_wr_addr, pkg_wr_areq, pkg_wr_size, pkg_wr_data,
    input  pkg_wr_en, pkg_wr_last
  );

  modport slave (
    input  pkg_wr_addr, pkg_wr_areq, pkg_wr_size, pkg_wr_data,
    output pkg_wr_en, pkg_wr_last
  );
endinterface

// File: rtl/pix_burst_packer.sv
// Packs 12-bit pixels two-per-word into a FWFT FIFO and issues fixed-size DDR write bursts.
// Optional PIX_FLUSH_EN: on frame end, flush the half-pair and zero-pad the tail to a full burst.
module pix_burst_packer #(
  parameter int unsigned BURST_WORDS  = 1024,
  parameter int unsigned FIFO_AW      = 11,
  parameter logic [31:0] DDR_BASE     = 32'h03C0_0000,
  parameter int unsigned FRAME_BURSTS = 2048
) (
  input  logic                clk_100m,
  input  logic                rst_n,
  input  logic [11:0]         img,
  input  logic                data_valid,
  input  logic                frame_valid,
  pix_burst_packer_if.master  wr,
  output logic [FIFO_AW:0]    fifo_level,
  output logic [11:0]         burst_cnt,
  output logic                frame_done,
  output logic                overflow
);

  typedef logic [FIFO_AW:0] lvl_t;
  localparam lvl_t DepthLvl = lvl_t'(2 ** FIFO_AW);
  localparam lvl_t BurstLvl = lvl_t'(BURST_WORDS);

  typedef enum logic [1:0] {StIdle, StReq, StXfer} state_e;
  state_e state_q, state_d;

  logic                fv_q, fv_rise, fv_fall;
  logic [11:0]         hold_q, hold_d;
  logic                hold_vld_q, hold_vld_d;
  logic [31:0]         word;
  logic                word_vld, push, pop, drop, fifo_clr;
  logic [31:0]         mem [2 ** FIFO_AW];
  logic [FIFO_AW-1:0]  wr_ptr_q, rd_ptr_q;
  lvl_t                level_q;
  logic                ovf_q;
  logic [11:0]         burst_cnt_q, burst_cnt_d;
  logic                restart_q, restart_d, restart;
  logic                frame_done_q, frame_done_d;
  logic                areq, last_beat, cnt_clr;

  assign fv_rise = frame_valid & ~fv_q;
  assign fv_fall = ~frame_valid & fv_q;

`ifdef PIX_FLUSH_EN
  logic flush_q, flush_d;
  lvl_t wr_ofs_q, wr_ofs_d;

  // wr_ofs counts pushed words modulo BURST_WORDS, so it is immune to pops mid-burst.
  always_comb begin
    flush_d  = flush_q;
    wr_ofs_d = wr_ofs_q;
    if (frame_valid)           flush_d = 1'b0;
    else if (fv_fall)          flush_d = 1'b1;
    else if (wr_ofs_q == '0)   flush_d = 1'b0;
    if (push) wr_ofs_d = (wr_ofs_q == BurstLvl - 1'b1) ? '0 : wr_ofs_q + 1'b1;
  end

  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      flush_q  <= 1'b0;
      wr_ofs_q <= '0;
    end else begin
      flush_q  <= flush_d;
      wr_ofs_q <= wr_ofs_d;
    end
  end

  assign fifo_clr = 1'b0;
`else
  assign fifo_clr = fv_rise && (state_q == StIdle) && (level_q < BurstLvl);
`endif

  always_comb begin
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q & ~fv_rise;
    word       = '0;
    word_vld   = 1'b0;
    if (data_valid && frame_valid) begin
      if (hold_vld_d) begin
        word       = {4'b0, img, 4'b0, hold_q};
        word_vld   = 1'b1;
        hold_vld_d = 1'b0;
      end else begin
        hold_d     = img;
        hold_vld_d = 1'b1;
      end
    end
`ifdef PIX_FLUSH_EN
    else if (fv_fall && hold_vld_q) begin
      word       = {20'b0, hold_q};
      word_vld   = 1'b1;
      hold_vld_d = 1'b0;
    end else if (flush_q && !frame_valid && wr_ofs_q != '0) begin
      word_vld   = 1'b1;
    end
`else
    else if (fv_fall) begin
      hold_vld_d = 1'b0;
    end
`endif
  end

  assign push = word_vld && ((level_q != DepthLvl) || pop);
  assign drop = word_vld && !push;

  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      fv_q       <= 1'b0;
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
    end else begin
      fv_q       <= frame_valid;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
    end
  end

  always_ff @(posedge clk_100m) begin
    if (push) mem[wr_ptr_q] <= word;
  end

  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (fifo_clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // A drop on the same cycle as a frame start still leaves the flag set.
  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n)       ovf_q <= 1'b0;
    else if (drop)    ovf_q <= 1'b1;
    else if (fv_rise) ovf_q <= 1'b0;
  end

  assign restart = restart_q | fv_rise;

  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      burst_cnt_q  <= '0;
      restart_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      burst_cnt_q  <= burst_cnt_d;
      restart_q    <= restart_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (!restart && level_q >= BurstLvl) state_d = StReq;
      StReq:   state_d = StXfer;
      StXfer:  if (wr.pkg_wr_en && wr.pkg_wr_last) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    areq         = (state_q == StReq);
    pop          = (state_q == StXfer) && wr.pkg_wr_en && (level_q != '0);
    last_beat    = (state_q == StXfer) && wr.pkg_wr_en && wr.pkg_wr_last;
    cnt_clr      = (state_q == StIdle) && restart;
    restart_d    = (state_q == StIdle) ? 1'b0 : restart;
    burst_cnt_d  = burst_cnt_q;
    frame_done_d = 1'b0;
    if (cnt_clr) begin
      burst_cnt_d = '0;
    end else if (last_beat) begin
      if (burst_cnt_q == 12'(FRAME_BURSTS - 1)) begin
        burst_cnt_d  = '0;
        frame_done_d = 1'b1;
      end else begin
        burst_cnt_d  = burst_cnt_q + 12'd1;
      end
    end
  end

  assign wr.pkg_wr_areq = areq;
  assign wr.pkg_wr_size = 32'(BURST_WORDS);
  assign wr.pkg_wr_addr = DDR_BASE + (32'(burst_cnt_q) * (32'(BURST_WORDS) << 2));
  assign wr.pkg_wr_data = (level_q == '0) ? '0 : mem[rd_ptr_q];
  assign fifo_level     = level_q;
  assign burst_cnt      = burst_cnt_q;
  assign frame_done     = frame_done_q;
  assign overflow       = ovf_q;

endmodule

// File: tb/tb_pix_burst_packer.sv
// Scoreboard bench for pix_burst_packer; frame length shortened to 4 bursts to reach the wrap.
module tb_pix_burst_packer;
  localparam int unsigned BW   = 1024;
  localparam logic [31:0] BASE = 32'h03C0_0000;

  logic        clk_100m = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] img = '0;
  logic        data_valid = 1'b0;
  logic        frame_valid = 1'b0;
  logic [11:0] fifo_level;
  logic [11:0] burst_cnt;
  logic        frame_done;
  logic        overflow;

  pix_burst_packer_if wr_if ();

  pix_burst_packer #(
    .BURST_WORDS (BW),
    .FIFO_AW     (11),
    .DDR_BASE    (BASE),
    .FRAME_BURSTS(4)
  ) dut (
    .clk_100m   (clk_100m),
    .rst_n      (rst_n),
    .img        (img),
    .data_valid (data_valid),
    .frame_valid(frame_valid),
    .wr         (wr_if),
    .fifo_level (fifo_level),
    .burst_cnt  (burst_cnt),
    .frame_done (frame_done),
    .overflow   (overflow)
  );

  always #5 clk_100m = ~clk_100m;

  int          n_chk = 0;
  int          n_pass = 0;
  int          areq_cnt = 0;
  int          fd_cnt = 0;
  int          bursts_taken = 0;
  logic [31:0] areq_addr = '0;
  logic [31:0] exp_q[$];
  logic [11:0] hold_m = '0;
  bit          hold_vld_m = 1'b0;

  always @(negedge clk_100m) begin
    if (rst_n) begin
      if (wr_if.pkg_wr_areq) begin
        areq_cnt  <= areq_cnt + 1;
        areq_addr <= wr_if.pkg_wr_addr;
      end
      if (frame_done) fd_cnt <= fd_cnt + 1;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_100m);
    #1;
  endtask

  task automatic set_fv(input logic v);
    frame_valid = v;
    hold_vld_m  = 1'b0;
    cyc(1);
  endtask

  // Pairs are modelled here; only the first 'keep' words formed are expected to survive.
  task automatic drive_pixels(input int n, input int first, input int keep);
    int made = 0;
    for (int i = 0; i < n; i++) begin
      img        = 12'(first + i);
      data_valid = 1'b1;
      if (hold_vld_m) begin
        if (made < keep) exp_q.push_back({4'b0, img, 4'b0, hold_m});
        made++;
        hold_vld_m = 1'b0;
      end else begin
        hold_m     = img;
        hold_vld_m = 1'b1;
      end
      cyc(1);
    end
    data_valid = 1'b0;
  endtask

  task automatic consume_burst(input string tag, input logic [31:0] exp_addr, input int beats,
                               input int restart_at);
    int          errs = 0;
    int          lim = 20000;
    logic [31:0] w, bad_got, bad_want;
    while (areq_cnt <= bursts_taken && lim > 0) begin
      cyc(1);
      lim--;
    end
    n_chk++;
    if (areq_cnt <= bursts_taken) begin
      $display("FAIL %s areq_timeout: areq count %0d, required > %0d", tag, areq_cnt, bursts_taken);
      return;
    end else n_pass++;
    bursts_taken++;
    n_chk++;
    if (areq_addr !== exp_addr) $display("FAIL %s areq_addr: got %h want %h", tag, areq_addr, exp_addr);
    else n_pass++;
    n_chk++;
    if (wr_if.pkg_wr_size !== 32'(BW))
      $display("FAIL %s size: got %0d want %0d", tag, wr_if.pkg_wr_size, BW);
    else n_pass++;
    cyc(2);
    bad_got  = '0;
    bad_want = '0;
    for (int i = 0; i < beats; i++) begin
      if (i == restart_at)     frame_valid = 1'b0;
      if (i == restart_at + 2) frame_valid = 1'b1;
      wr_if.pkg_wr_en   = 1'b1;
      wr_if.pkg_wr_last = (i == BW - 1);
      if (exp_q.size() == 0) begin
        if (errs == 0) bad_got = wr_if.pkg_wr_data;
        errs++;
      end else begin
        w = exp_q.pop_front();
        if (wr_if.pkg_wr_data !== w) begin
          if (errs == 0) begin
            bad_got  = wr_if.pkg_wr_data;
            bad_want = w;
          end
          errs++;
        end
      end
      if (i == BW - 1) begin
        n_chk++;
        if (wr_if.pkg_wr_addr !== exp_addr)
          $display("FAIL %s addr_at_last: got %h want %h", tag, wr_if.pkg_wr_addr, exp_addr);
        else n_pass++;
      end
      cyc(1);
    end
    wr_if.pkg_wr_en   = 1'b0;
    wr_if.pkg_wr_last = 1'b0;
    n_chk++;
    if (errs !== 0)
      $display("FAIL %s data: %0d bad beats, first got %h want %h", tag, errs, bad_got, bad_want);
    else n_pass++;
  endtask

  task automatic test_reset;
    cyc(1);
    n_chk++; if (wr_if.pkg_wr_areq !== 1'b0) $display("FAIL rst_areq: got %b want 0", wr_if.pkg_wr_areq); else n_pass++;
    n_chk++; if (wr_if.pkg_wr_addr !== BASE) $display("FAIL rst_addr: got %h want %h", wr_if.pkg_wr_addr, BASE); else n_pass++;
    n_chk++; if (fifo_level !== 12'd0) $display("FAIL rst_level: got %0d want 0", fifo_level); else n_pass++;
    n_chk++; if (burst_cnt !== 12'd0) $display("FAIL rst_burst_cnt: got %0d want 0", burst_cnt); else n_pass++;
    n_chk++; if (frame_done !== 1'b0) $display("FAIL rst_frame_done: got %b want 0", frame_done); else n_pass++;
    n_chk++; if (overflow !== 1'b0) $display("FAIL rst_overflow: got %b want 0", overflow); else n_pass++;
    n_chk++; if (wr_if.pkg_wr_data !== 32'h0) $display("FAIL rst_data: got %h want 0", wr_if.pkg_wr_data); else n_pass++;
    rst_n = 1'b1;
    cyc(2);
  endtask

  task automatic test_first_burst;
    set_fv(1'b1);
    drive_pixels(2048, 0, 1024);
    n_chk++;
    if (wr_if.pkg_wr_data !== 32'h0001_0000)
      $display("FAIL head_word0: got %h want 00010000", wr_if.pkg_wr_data);
    else n_pass++;
    consume_burst("burst0", BASE, BW, -1);
    n_chk++; if (burst_cnt !== 12'd1) $display("FAIL burst0_cnt: got %0d want 1", burst_cnt); else n_pass++;
    cyc(20);
    n_chk++; if (areq_cnt !== 1) $display("FAIL burst0_areq_count: got %0d want 1", areq_cnt); else n_pass++;
    n_chk++; if (fifo_level !== 12'd0) $display("FAIL burst0_level: got %0d want 0", fifo_level); else n_pass++;
  endtask

  task automatic test_overflow;
    drive_pixels(8200, 2048, 2048);
    n_chk++; if (fifo_level !== 12'd2048) $display("FAIL ovf_level: got %0d want 2048", fifo_level); else n_pass++;
    n_chk++; if (overflow !== 1'b1) $display("FAIL ovf_flag: got %b want 1", overflow); else n_pass++;
    consume_burst("ovf_b1", BASE + 32'h1000, BW, -1);
    consume_burst("ovf_b2", BASE + 32'h2000, BW, -1);
    n_chk++; if (burst_cnt !== 12'd3) $display("FAIL ovf_cnt: got %0d want 3", burst_cnt); else n_pass++;
    n_chk++; if (overflow !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", overflow); else n_pass++;
  endtask

  task automatic test_frame_wrap;
    drive_pixels(2048, 100, 1024);
    consume_burst("wrap", BASE + 32'h3000, BW, -1);
    n_chk++; if (frame_done !== 1'b1) $display("FAIL wrap_done_high: got %b want 1", frame_done); else n_pass++;
    cyc(4);
    n_chk++; if (fd_cnt !== 1) $display("FAIL wrap_done_cycles: got %0d want 1", fd_cnt); else n_pass++;
    n_chk++; if (burst_cnt !== 12'd0) $display("FAIL wrap_cnt: got %0d want 0", burst_cnt); else n_pass++;
    n_chk++; if (wr_if.pkg_wr_addr !== BASE) $display("FAIL wrap_addr: got %h want %h", wr_if.pkg_wr_addr, BASE); else n_pass++;
  endtask

`ifdef PIX_FLUSH_EN
  task automatic test_residual;
    drive_pixels(21, 0, 10);
    exp_q.push_back(32'h0000_0014);
    for (int i = 0; i < 1013; i++) exp_q.push_back(32'h0);
    set_fv(1'b0);
    consume_burst("flush", BASE, BW, -1);
    n_chk++; if (fifo_level !== 12'd0) $display("FAIL flush_level: got %0d want 0", fifo_level); else n_pass++;
    set_fv(1'b1);
    cyc(3);
    n_chk++; if (overflow !== 1'b0) $display("FAIL flush_ovf_clr: got %b want 0", overflow); else n_pass++;
    n_chk++; if (burst_cnt !== 12'd0) $display("FAIL flush_cnt: got %0d want 0", burst_cnt); else n_pass++;
  endtask
`else
  task automatic test_residual;
    drive_pixels(20, 7, 0);
    n_chk++; if (fifo_level !== 12'd10) $display("FAIL resid_level_before: got %0d want 10", fifo_level); else n_pass++;
    set_fv(1'b0);
    set_fv(1'b1);
    n_chk++; if (fifo_level !== 12'd0) $display("FAIL resid_level_after: got %0d want 0", fifo_level); else n_pass++;
    n_chk++; if (wr_if.pkg_wr_data !== 32'h0) $display("FAIL resid_data: got %h want 0", wr_if.pkg_wr_data); else n_pass++;
    n_chk++; if (overflow !== 1'b0) $display("FAIL resid_ovf_clr: got %b want 0", overflow); else n_pass++;
    cyc(20);
    n_chk++; if (areq_cnt !== bursts_taken) $display("FAIL resid_no_areq: got %0d want %0d", areq_cnt, bursts_taken); else n_pass++;
  endtask
`endif

  task automatic test_restart_xfer;
    drive_pixels(2048, 300, 1024);
    consume_burst("rs_a", BASE, BW, -1);
    n_chk++; if (burst_cnt !== 12'd1) $display("FAIL rs_cnt_mid: got %0d want 1", burst_cnt); else n_pass++;
    drive_pixels(2048, 500, 1024);
    consume_burst("rs_b", BASE + 32'h1000, BW, 500);
    cyc(3);
    n_chk++; if (burst_cnt !== 12'd0) $display("FAIL rs_cnt_after: got %0d want 0", burst_cnt); else n_pass++;
    n_chk++; if (wr_if.pkg_wr_addr !== BASE) $display("FAIL rs_addr_after: got %h want %h", wr_if.pkg_wr_addr, BASE); else n_pass++;
    n_chk++; if (areq_cnt !== bursts_taken) $display("FAIL rs_no_areq: got %0d want %0d", areq_cnt, bursts_taken); else n_pass++;
  endtask

  task automatic test_reset_xfer;
    drive_pixels(8196, 900, 2048);
    n_chk++; if (overflow !== 1'b1) $display("FAIL rx_ovf_set: got %b want 1", overflow); else n_pass++;
    consume_burst("rx_a", BASE, BW, -1);
    consume_burst("rx_b", BASE + 32'h1000, 100, -1);
    rst_n = 1'b0;
    cyc(1);
    n_chk++; if (wr_if.pkg_wr_areq !== 1'b0) $display("FAIL rx_areq: got %b want 0", wr_if.pkg_wr_areq); else n_pass++;
    n_chk++; if (fifo_level !== 12'd0) $display("FAIL rx_level: got %0d want 0", fifo_level); else n_pass++;
    n_chk++; if (burst_cnt !== 12'd0) $display("FAIL rx_cnt: got %0d want 0", burst_cnt); else n_pass++;
    n_chk++; if (overflow !== 1'b0) $display("FAIL rx_ovf: got %b want 0", overflow); else n_pass++;
    n_chk++; if (wr_if.pkg_wr_data !== 32'h0) $display("FAIL rx_data: got %h want 0", wr_if.pkg_wr_data); else n_pass++;
    exp_q.delete();
    rst_n = 1'b1;
    cyc(2);
  endtask

  initial begin
    wr_if.pkg_wr_en   = 1'b0;
    wr_if.pkg_wr_last = 1'b0;
    rst_n             = 1'b0;
    cyc(3);
    test_reset();
    test_first_burst();
    test_overflow();
    test_frame_wrap();
    test_residual();
    test_restart_xfer();
    test_reset_xfer();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end

endmodule
